// File: rtl/ddr3_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_ctrl
//  Purpose  : DDR3 power-up/initialisation sequencer with periodic auto-refresh.
//             Define DDR3_FAST_SIM_EN to shorten RESET#/CKE waits to 100/200 cycles.
//  Revision : 1.0  initial release
// ============================================================================
module ddr3_ctrl #(
  parameter real         DDR_CLK_PERIOD = 3.0,
  parameter real         DDR_tRESET     = 200000.0,
  parameter real         DDR_tCKE       = 500000.0,
  parameter real         DDR_tXPR       = 170.0,
  parameter int          DDR_tMRD       = 4,
  parameter int          DDR_tMOD       = 12,
  parameter real         DDR_tZQinit    = 1536.0,
  parameter real         DDR_tREFI      = 7800.0,
  parameter real         DDR_tRFC       = 160.0,
  parameter logic [13:0] MR0_VAL        = 14'h0520,
  parameter logic [13:0] MR1_VAL        = 14'h0044,
  parameter logic [13:0] MR2_VAL        = 14'h0008,
  parameter logic [13:0] MR3_VAL        = 14'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ddr_reset_n,
  output logic        ddr_cke,
  output logic        ddr_cs_n,
  output logic        ddr_ras_n,
  output logic        ddr_cas_n,
  output logic        ddr_we_n,
  output logic [2:0]  ddr_ba,
  output logic [13:0] ddr_addr,
  output logic        ddr_odt,
  output logic        init_done
);

`ifdef DDR3_FAST_SIM_EN
  localparam logic [31:0] c_n_treset = 32'd100;
  localparam logic [31:0] c_n_tcke   = 32'd200;
`else
  localparam logic [31:0] c_n_treset = 32'($rtoi($ceil(DDR_tRESET / DDR_CLK_PERIOD)));
  localparam logic [31:0] c_n_tcke   = 32'($rtoi($ceil(DDR_tCKE / DDR_CLK_PERIOD)));
`endif
  localparam logic [31:0] c_n_txpr   = 32'($rtoi($ceil(DDR_tXPR / DDR_CLK_PERIOD)));
  localparam logic [31:0] c_n_tzq    = 32'($rtoi($ceil(DDR_tZQinit / DDR_CLK_PERIOD)));
  localparam logic [31:0] c_n_trefi  = 32'($rtoi($ceil(DDR_tREFI / DDR_CLK_PERIOD)));
  localparam logic [31:0] c_n_trfc   = 32'($rtoi($ceil(DDR_tRFC / DDR_CLK_PERIOD)));
  localparam logic [31:0] c_mrd_last = 32'(DDR_tMRD - 1);
  localparam logic [31:0] c_mod_last = 32'(DDR_tMOD - 1);

  typedef enum logic [3:0] {
    RST_LOW,
    CKE_WAIT,
    XPR_WAIT,
    MRS2,
    MRS3,
    MRS1,
    MRS0,
    MOD_WAIT,
    ZQCL,
    ZQ_WAIT,
    IDLE,
    RFC_WAIT
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_ref_cnt;

  // Each MRSx/ZQCL/RFC_WAIT state is entered on the edge that drives its
  // command, so r_cnt measures cycles elapsed since that command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RST_LOW;
      r_cnt       <= '0;
      r_ref_cnt   <= '0;
      ddr_reset_n <= 1'b0;
      ddr_cke     <= 1'b0;
      ddr_cs_n    <= 1'b1;
      ddr_ras_n   <= 1'b1;
      ddr_cas_n   <= 1'b1;
      ddr_we_n    <= 1'b1;
      ddr_ba      <= '0;
      ddr_addr    <= '0;
      ddr_odt     <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      ddr_cs_n  <= 1'b0;
      ddr_ras_n <= 1'b1;
      ddr_cas_n <= 1'b1;
      ddr_we_n  <= 1'b1;
      ddr_ba    <= '0;
      ddr_addr  <= '0;
      ddr_odt   <= 1'b0;
      r_cnt     <= r_cnt + 32'd1;
      r_ref_cnt <= r_ref_cnt + 32'd1;

      case (r_state)
        RST_LOW: begin
          ddr_cs_n <= 1'b1;
          if (r_cnt == c_n_treset - 32'd1) begin
            ddr_reset_n <= 1'b1;
            r_cnt       <= '0;
            r_state     <= CKE_WAIT;
          end
        end

        CKE_WAIT: begin
          if (r_cnt == c_n_tcke - 32'd1) begin
            ddr_cke <= 1'b1;
            r_cnt   <= '0;
            r_state <= XPR_WAIT;
          end else begin
            ddr_cs_n <= 1'b1;
          end
        end

        XPR_WAIT: begin
          if (r_cnt == c_n_txpr - 32'd1) begin
            ddr_ras_n <= 1'b0;
            ddr_cas_n <= 1'b0;
            ddr_we_n  <= 1'b0;
            ddr_ba    <= 3'd2;
            ddr_addr  <= MR2_VAL;
            r_cnt     <= '0;
            r_state   <= MRS2;
          end
        end

        MRS2: begin
          if (r_cnt == c_mrd_last) begin
            ddr_ras_n <= 1'b0;
            ddr_cas_n <= 1'b0;
            ddr_we_n  <= 1'b0;
            ddr_ba    <= 3'd3;
            ddr_addr  <= MR3_VAL;
            r_cnt     <= '0;
            r_state   <= MRS3;
          end
        end

        MRS3: begin
          if (r_cnt == c_mrd_last) begin
            ddr_ras_n <= 1'b0;
            ddr_cas_n <= 1'b0;
            ddr_we_n  <= 1'b0;
            ddr_ba    <= 3'd1;
            ddr_addr  <= MR1_VAL;
            r_cnt     <= '0;
            r_state   <= MRS1;
          end
        end

        MRS1: begin
          if (r_cnt == c_mrd_last) begin
            ddr_ras_n <= 1'b0;
            ddr_cas_n <= 1'b0;
            ddr_we_n  <= 1'b0;
            ddr_ba    <= 3'd0;
            ddr_addr  <= MR0_VAL;
            r_cnt     <= '0;
            r_state   <= MRS0;
          end
        end

        MRS0: begin
          r_state <= MOD_WAIT;
        end

        MOD_WAIT: begin
          if (r_cnt == c_mod_last) begin
            ddr_we_n <= 1'b0;
            ddr_addr <= 14'h0400;
            r_cnt    <= '0;
            r_state  <= ZQCL;
          end
        end

        ZQCL: begin
          r_state <= ZQ_WAIT;
        end

        ZQ_WAIT: begin
          if (r_cnt == c_n_tzq - 32'd1) begin
            init_done <= 1'b1;
            r_ref_cnt <= '0;
            r_state   <= IDLE;
          end
        end

        IDLE: begin
          if (r_ref_cnt == c_n_trefi - 32'd1) begin
            ddr_ras_n <= 1'b0;
            ddr_cas_n <= 1'b0;
            r_ref_cnt <= '0;
            r_cnt     <= '0;
            r_state   <= RFC_WAIT;
          end
        end

        RFC_WAIT: begin
          if (r_cnt == c_n_trfc - 32'd1) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= RST_LOW;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr3_ctrl
//  Purpose  : Directed bench for ddr3_ctrl: init sequence, refresh, async reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddr3_ctrl;

  logic        clk;
  logic        reset;
  logic        ddr_reset_n;
  logic        ddr_cke;
  logic        ddr_cs_n;
  logic        ddr_ras_n;
  logic        ddr_cas_n;
  logic        ddr_we_n;
  logic [2:0]  ddr_ba;
  logic [13:0] ddr_addr;
  logic        ddr_odt;
  logic        init_done;

  int          checks;
  int          errors;
  int          bad_desel;
  int          bad_nop;
  int          n;
  logic [3:0]  cmd;

  // 299 ns and 598.5 ns exercise the ceiling conversion and give 100/200 cycles.
  ddr3_ctrl #(
    .DDR_tRESET (299.0),
    .DDR_tCKE   (598.5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ddr_reset_n (ddr_reset_n),
    .ddr_cke     (ddr_cke),
    .ddr_cs_n    (ddr_cs_n),
    .ddr_ras_n   (ddr_ras_n),
    .ddr_cas_n   (ddr_cas_n),
    .ddr_we_n    (ddr_we_n),
    .ddr_ba      (ddr_ba),
    .ddr_addr    (ddr_addr),
    .ddr_odt     (ddr_odt),
    .init_done   (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`define CHECK(tag, obs, exp) \
  checks++; \
  assert ((obs) === (exp)) else begin \
    errors++; \
    $error("FAIL %s observed=%0d expected=%0d", tag, (obs), (exp)); \
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = ddr_reset_n, 1 = ddr_cke, 2 = init_done
  task automatic wait_rise(input int which, input int limit, output int cnt);
    logic s;
    cnt = 0;
    s   = 1'b0;
    do begin
      tick();
      cnt++;
      case (which)
        0:       s = ddr_reset_n;
        1:       s = ddr_cke;
        default: s = init_done;
      endcase
      if (which < 2 && s !== 1'b1 && ddr_cs_n !== 1'b1) bad_desel++;
      if (which == 1 && ddr_reset_n !== 1'b1) bad_desel++;
    end while (s !== 1'b1 && cnt < limit);
  endtask

  task automatic wait_cmd(input int limit, output int cnt, output logic [3:0] c);
    cnt = 0;
    c   = 4'b0111;
    do begin
      tick();
      cnt++;
      c = {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n};
      if (c[3]) bad_nop++;
      if (c == 4'b0111 && (ddr_ba !== 3'd0 || ddr_addr !== 14'd0)) bad_nop++;
    end while ((c == 4'b0111 || c[3]) && cnt < limit);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0]  exp_ba   [4];
    logic [13:0] exp_addr [4];
    int          exp_gap  [4];

    exp_ba   = '{3'd2, 3'd3, 3'd1, 3'd0};
    exp_addr = '{14'h0008, 14'h0000, 14'h0044, 14'h0520};
    exp_gap  = '{57, 4, 4, 4};
    checks    = 0;
    errors    = 0;
    bad_desel = 0;
    bad_nop   = 0;
    reset     = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    `CHECK("rst_reset_n", ddr_reset_n, 1'b0)
    `CHECK("rst_cke", ddr_cke, 1'b0)
    `CHECK("rst_cs_n", ddr_cs_n, 1'b1)
    `CHECK("rst_ras_cas_we", {ddr_ras_n, ddr_cas_n, ddr_we_n}, 3'b111)
    `CHECK("rst_ba", ddr_ba, 3'd0)
    `CHECK("rst_addr", ddr_addr, 14'd0)
    `CHECK("rst_odt", ddr_odt, 1'b0)
    `CHECK("rst_init_done", init_done, 1'b0)

    release_reset();
    wait_rise(0, 1000, n);
    `CHECK("reset_n_delay", n, 100)
    wait_rise(1, 1000, n);
    `CHECK("cke_delay", n, 200)
    `CHECK("deselect_before_cke", bad_desel, 0)
    `CHECK("init_done_low_pre_mrs", init_done, 1'b0)

    for (int i = 0; i < 4; i++) begin
      wait_cmd(200, n, cmd);
      `CHECK("mrs_gap", n, exp_gap[i])
      `CHECK("mrs_cmd", cmd, 4'b0000)
      `CHECK("mrs_ba", ddr_ba, exp_ba[i])
      `CHECK("mrs_addr", ddr_addr, exp_addr[i])
    end

    wait_cmd(200, n, cmd);
    `CHECK("zqcl_gap", n, 12)
    `CHECK("zqcl_cmd", cmd, 4'b0110)
    `CHECK("zqcl_a10", ddr_addr[10], 1'b1)

    wait_rise(2, 2000, n);
    `CHECK("init_done_delay", n, 512)

    for (int i = 0; i < 2; i++) begin
      wait_cmd(5000, n, cmd);
      `CHECK("ref_gap", n, 2600)
      `CHECK("ref_cmd", cmd, 4'b0001)
    end
    `CHECK("init_done_sticky", init_done, 1'b1)
    `CHECK("cke_held", ddr_cke, 1'b1)
    `CHECK("reset_n_held", ddr_reset_n, 1'b1)
    `CHECK("odt_held", ddr_odt, 1'b0)
    `CHECK("nop_cycles_clean", bad_nop, 0)

    // Restart, then hit reset asynchronously inside the MRS1 spacing.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    release_reset();
    wait_rise(0, 1000, n);
    `CHECK("restart_reset_n_delay", n, 100)
    wait_rise(1, 1000, n);
    `CHECK("restart_cke_delay", n, 200)
    for (int i = 0; i < 3; i++) begin
      wait_cmd(200, n, cmd);
      `CHECK("restart_mrs_gap", n, exp_gap[i])
    end
    `CHECK("restart_mrs1_ba", ddr_ba, 3'd1)
    tick();
    tick();
    `CHECK("pre_async_cs_n", ddr_cs_n, 1'b0)
    #2;
    reset = 1'b1;
    #1;
    `CHECK("async_reset_n", ddr_reset_n, 1'b0)
    `CHECK("async_cke", ddr_cke, 1'b0)
    `CHECK("async_cs_n", ddr_cs_n, 1'b1)
    `CHECK("async_ras_cas_we", {ddr_ras_n, ddr_cas_n, ddr_we_n}, 3'b111)
    `CHECK("async_init_done", init_done, 1'b0)

    repeat (2) @(posedge clk);
    bad_desel = 0;
    bad_nop   = 0;
    release_reset();
    wait_rise(0, 1000, n);
    `CHECK("post_reset_n_delay", n, 100)
    wait_rise(1, 1000, n);
    `CHECK("post_cke_delay", n, 200)
    `CHECK("post_deselect", bad_desel, 0)
    wait_cmd(200, n, cmd);
    `CHECK("post_mrs2_gap", n, 57)
    `CHECK("post_mrs2_cmd", cmd, 4'b0000)
    `CHECK("post_mrs2_ba", ddr_ba, 3'd2)
    `CHECK("post_mrs2_addr", ddr_addr, 14'h0008)
    `CHECK("post_nop_clean", bad_nop, 0)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

`undef CHECK

endmodule
`default_nettype wire

// File: doc/ddr3_ctrl.md
Name: ddr3_ctrl

Overview:
DDR3 SDRAM command-sequencer core clocked at the DDR clock. It sequences JEDEC power-up and initialisation: RESET#, CKE, mode-register programming MR2/MR3/MR1/MR0, then ZQCL calibration. It then issues periodic auto-refresh and flags init_done. It sits between the user-interface layer and the DDR3 PHY pins; there is no data path in this block.

Parameters:
DDR_CLK_PERIOD  3.0  real, DDR clock period in ns
DDR_tRESET  200000.0  real ns, RESET# low time
DDR_tCKE  500000.0  real ns, RESET# high to CKE high
DDR_tXPR  170.0  real ns, CKE high to first MRS
DDR_tMRD  4  integer cycles, MRS to MRS spacing
DDR_tMOD  12  integer cycles, last MRS to ZQCL
DDR_tZQinit  1536.0  real ns, ZQCL duration
DDR_tREFI  7800.0  real ns, refresh interval
DDR_tRFC  160.0  real ns, refresh cycle time
MR0_VAL / MR1_VAL / MR2_VAL / MR3_VAL  14'h0520 / 14'h0044 / 14'h0008 / 14'h0000  mode-register address payloads

Ports:
clk  in  1  DDR clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
ddr_reset_n  out  1  DDR3 RESET#
ddr_cke  out  1  clock enable
ddr_cs_n  out  1  chip select
ddr_ras_n  out  1  RAS#
ddr_cas_n  out  1  CAS#
ddr_we_n  out  1  WE#
ddr_ba  out  3  bank address
ddr_addr  out  14  address bus
ddr_odt  out  1  on-die termination, held 0
init_done  out  1  high once initialisation completes

Behaviour:
- Time conversion: each real-ns parameter maps to integer cycles N = ceil(t / DDR_CLK_PERIOD), computed at elaboration as localparams. Counters are 32-bit.
- All outputs are registered.
- Reset values: ddr_reset_n=0, cke=0, cs_n=1, ras_n=cas_n=we_n=1, ba=0, addr=0, odt=0, init_done=0. State is RST_LOW and the counter is 0.
- Reset asserted at any time returns immediately to the reset values and RST_LOW. Releasing reset restarts the full sequence.
- Command encoding (cs,ras,cas,we):
  - NOP 0111
  - MRS 0000
  - REF 0001
  - ZQCL 0110 with addr[10]=1
  - DESELECT is cs_n=1.
- Every non-command cycle drives NOP with ba=0 and addr=0. The exception is RST_LOW and CKE_WAIT, which drive DESELECT.
- State machine:
  - RST_LOW: hold ddr_reset_n=0 for N_tRESET cycles, then drive ddr_reset_n=1 → CKE_WAIT.
  - CKE_WAIT: N_tCKE cycles, then drive cke=1 → XPR_WAIT.
  - XPR_WAIT: N_tXPR cycles → MRS2.
  - MRS2, MRS3, MRS1, MRS0: each issues one MRS cycle, with ba = 2, 3, 1, 0 respectively and addr = the matching MRx_VAL. The cycle is followed by (DDR_tMRD-1) NOP cycles, so consecutive MRS commands start exactly DDR_tMRD cycles apart. After MRS0 → MOD_WAIT.
  - MOD_WAIT: MRS0 to ZQCL is DDR_tMOD cycles → ZQCL.
  - ZQCL: one-cycle ZQCL → ZQ_WAIT.
  - ZQ_WAIT: N_tZQinit cycles, then init_done=1 → IDLE.
  - IDLE: refresh counter counts; after N_tREFI cycles issue REF → RFC_WAIT.
  - RFC_WAIT: N_tRFC cycles → IDLE, with the refresh counter restarting from the REF cycle.
- init_done is sticky high until reset.
- cke stays 1 and ddr_reset_n stays 1 after they rise.
- Exactly one command is issued per cycle.

Optional Feature:
- Macro: DDR3_FAST_SIM_EN.
- When defined, N_tRESET is forced to 100 cycles and N_tCKE to 200 cycles, for short simulations. All other timings are unchanged.
- When undefined, all timings derive from the parameters as above.

Test Plan:
- Reset release, defaults (period 3.0): ddr_reset_n rises after 66667 cycles, then cke rises 166667 cycles later. Before that: cs_n=1, init_done=0.
- MRS sequence: first MRS occurs 57 cycles after cke high.
  - Order and payloads: ba=2 addr=0x0008, ba=3 addr=0x0000, ba=1 addr=0x0044, ba=0 addr=0x0520.
  - Spacing: consecutive MRS 4 cycles apart.
  - NOP on every other cycle.
- ZQCL: issued 12 cycles after the MR0 MRS, with addr[10]=1 and ras_n=cas_n=1, we_n=0. init_done rises 512 cycles after ZQCL.
- Refresh: first REF 2600 cycles after entering IDLE, the next REF 2600 cycles after that. No other command within the 54 cycles after each REF.
- Mid-sequence reset: assert reset during the MRS1 spacing. Outputs return asynchronously to the reset values, and after release the full sequence restarts from RST_LOW.
- Build with DDR3_FAST_SIM_EN: ddr_reset_n rises 100 cycles after reset release and cke 200 cycles later; the rest of the sequence is identical.
